// File: rtl/time_set_rx.sv
// time_set_rx: serial receiver for the 7-byte time-set frame (A5, hour, minute, second, day, month, xor).
// Define TIME_SET_RX_PARITY_EN to add an even-parity bit to every byte.
module time_set_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic       set_valid,
    output logic [4:0] set_hour,
    output logic [5:0] set_minute,
    output logic [5:0] set_second,
    output logic [4:0] set_day,
    output logic [3:0] set_month,
    output logic       err_valid,
    output logic [2:0] err_code,
    output logic       busy
);

    localparam int              CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   CNT_MAX   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_HALF  = CW'(CLKS_PER_BIT / 2);
    localparam int              GAP_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int              GW        = $clog2(GAP_LIMIT + 2);
    localparam logic [GW-1:0]   GAP_SAT   = GW'(GAP_LIMIT + 1);

    localparam logic [2:0] ERR_FRAME   = 3'd1;
    localparam logic [2:0] ERR_CSUM    = 3'd3;
    localparam logic [2:0] ERR_RANGE   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;
`ifdef TIME_SET_RX_PARITY_EN
    localparam logic [2:0] ERR_PARITY  = 3'd2;
    typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} bit_state_e;
`else
    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
`endif
    typedef enum logic [1:0] {P_WAIT_SYNC, P_PAYLOAD, P_CHECK} parse_state_e;

    logic rx_s1_q, rx_s2_q, rx_prev_q;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    bit_state_e  bstate_q, bstate_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bitn_q, bitn_d;
    logic [7:0]  shift_q, shift_d;
    logic        byte_done, frame_err;
`ifdef TIME_SET_RX_PARITY_EN
    logic        par_bad_q, par_bad_d, par_err;
`endif

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        bstate_d  = bstate_q;
        cnt_d     = cnt_q + CW'(1);
        bitn_d    = bitn_q;
        shift_d   = shift_q;
        byte_done = 1'b0;
        frame_err = 1'b0;
`ifdef TIME_SET_RX_PARITY_EN
        par_bad_d = par_bad_q;
        par_err   = 1'b0;
`endif
        case (bstate_q)
            B_IDLE: begin
                cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) bstate_d = B_START;
            end
            B_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d    = '0;
                    bitn_d   = 3'd0;
                    bstate_d = rx_s2_q ? B_IDLE : B_DATA;
                end
            end
            B_DATA: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d   = '0;
                    shift_d = {rx_s2_q, shift_q[7:1]};
                    bitn_d  = bitn_q + 3'd1;
`ifdef TIME_SET_RX_PARITY_EN
                    if (bitn_q == 3'd7) bstate_d = B_PARITY;
`else
                    if (bitn_q == 3'd7) bstate_d = B_STOP;
`endif
                end
            end
`ifdef TIME_SET_RX_PARITY_EN
            B_PARITY: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d     = '0;
                    par_bad_d = rx_s2_q ^ (^shift_q);
                    bstate_d  = B_STOP;
                end
            end
`endif
            B_STOP: begin
                if (cnt_q == CNT_MAX) begin
                    cnt_d    = '0;
                    bstate_d = B_IDLE;
                    if (!rx_s2_q) frame_err = 1'b1;
`ifdef TIME_SET_RX_PARITY_EN
                    else if (par_bad_q) par_err = 1'b1;
`endif
                    else byte_done = 1'b1;
                end
            end
            default: bstate_d = B_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            bstate_q  <= B_IDLE;
            cnt_q     <= '0;
            bitn_q    <= '0;
            shift_q   <= '0;
`ifdef TIME_SET_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            bstate_q  <= bstate_d;
            cnt_q     <= cnt_d;
            bitn_q    <= bitn_d;
            shift_q   <= shift_d;
`ifdef TIME_SET_RX_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    parse_state_e pstate_q, pstate_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      csum_q, csum_d;
    logic [4:0][7:0] shadow_q, shadow_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic            set_valid_q, set_valid_d, err_valid_q, err_valid_d;
    logic [2:0]      err_code_q, err_code_d;
    logic [4:0]      hour_q, hour_d, day_q, day_d;
    logic [5:0]      minute_q, minute_d, second_q, second_d;
    logic [3:0]      month_q, month_d;
    logic            timeout, range_bad, fail;
    logic [2:0]      fail_code;

    assign timeout   = (pstate_q != P_WAIT_SYNC) && (gap_q == GAP_SAT);
    assign range_bad = (shadow_q[0] > 8'd23) || (shadow_q[1] > 8'd59) || (shadow_q[2] > 8'd59) ||
                       (shadow_q[3] > 8'd30) || (shadow_q[4] > 8'd11);

    always_comb begin
        pstate_d    = pstate_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        shadow_d    = shadow_q;
        set_valid_d = 1'b0;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;
        hour_d      = hour_q;
        minute_d    = minute_q;
        second_d    = second_q;
        day_d       = day_q;
        month_d     = month_q;
        fail        = 1'b0;
        fail_code   = err_code_q;

        // Gap counter only runs while a frame is open and the line is between bytes.
        if ((pstate_q != P_WAIT_SYNC) && (bstate_q == B_IDLE))
            gap_d = (gap_q == GAP_SAT) ? gap_q : gap_q + GW'(1);
        else
            gap_d = '0;

        if (frame_err) begin
            fail = 1'b1; fail_code = ERR_FRAME;
        end
`ifdef TIME_SET_RX_PARITY_EN
        else if (par_err) begin
            fail = 1'b1; fail_code = ERR_PARITY;
        end
`endif
        else if (timeout) begin
            fail = 1'b1; fail_code = ERR_TIMEOUT;
        end else if (byte_done) begin
            case (pstate_q)
                P_WAIT_SYNC: begin
                    if (shift_q == 8'hA5) begin
                        pstate_d = P_PAYLOAD;
                        idx_d    = 3'd0;
                        csum_d   = 8'h00;
                    end
                end
                P_PAYLOAD: begin
                    shadow_d[idx_q] = shift_q;
                    csum_d          = csum_q ^ shift_q;
                    idx_d           = idx_q + 3'd1;
                    if (idx_q == 3'd4) pstate_d = P_CHECK;
                end
                P_CHECK: begin
                    if (shift_q != csum_q) begin
                        fail = 1'b1; fail_code = ERR_CSUM;
                    end else if (range_bad) begin
                        fail = 1'b1; fail_code = ERR_RANGE;
                    end else begin
                        pstate_d    = P_WAIT_SYNC;
                        set_valid_d = 1'b1;
                        hour_d      = shadow_q[0][4:0];
                        minute_d    = shadow_q[1][5:0];
                        second_d    = shadow_q[2][5:0];
                        day_d       = shadow_q[3][4:0];
                        month_d     = shadow_q[4][3:0];
                    end
                end
                default: pstate_d = P_WAIT_SYNC;
            endcase
        end

        if (fail) begin
            pstate_d    = P_WAIT_SYNC;
            err_valid_d = 1'b1;
            err_code_d  = fail_code;
        end
    end

    // NOTE: the shadow bytes are a handful of flops, so they take the reset like everything else.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pstate_q    <= P_WAIT_SYNC;
            idx_q       <= '0;
            csum_q      <= '0;
            shadow_q    <= '0;
            gap_q       <= '0;
            set_valid_q <= 1'b0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            hour_q      <= '0;
            minute_q    <= '0;
            second_q    <= '0;
            day_q       <= '0;
            month_q     <= '0;
        end else begin
            pstate_q    <= pstate_d;
            idx_q       <= idx_d;
            csum_q      <= csum_d;
            shadow_q    <= shadow_d;
            gap_q       <= gap_d;
            set_valid_q <= set_valid_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            hour_q      <= hour_d;
            minute_q    <= minute_d;
            second_q    <= second_d;
            day_q       <= day_d;
            month_q     <= month_d;
        end
    end

    assign set_valid  = set_valid_q;
    assign set_hour   = hour_q;
    assign set_minute = minute_q;
    assign set_second = second_q;
    assign set_day    = day_q;
    assign set_month  = month_q;
    assign err_valid  = err_valid_q;
    assign err_code   = err_code_q;
    assign busy       = (pstate_q != P_WAIT_SYNC);

endmodule

// File: tb/tb_time_set_rx.sv
// tb_time_set_rx: table-driven frame vectors plus timeout and reset sequences for time_set_rx.
`timescale 1ns/1ps
module tb_time_set_rx;

    localparam int CPB = 16;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       rx    = 1'b1;
    logic       set_valid, err_valid, busy;
    logic [4:0] set_hour, set_day;
    logic [5:0] set_minute, set_second;
    logic [3:0] set_month;
    logic [2:0] err_code;

    time_set_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20)) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .set_valid  (set_valid),
        .set_hour   (set_hour),
        .set_minute (set_minute),
        .set_second (set_second),
        .set_day    (set_day),
        .set_month  (set_month),
        .err_valid  (err_valid),
        .err_code   (err_code),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    int set_cnt  = 0;
    int err_cnt  = 0;
    int both_cnt = 0;

    always @(negedge clock) begin
        if (reset) begin
            if (set_valid) set_cnt++;
            if (err_valid) err_cnt++;
            if (set_valid && err_valid) both_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  frame [7];
        int          bad_stop_idx;
        int          exp_set;
        int          exp_err;
        logic [2:0]  exp_code;
        logic [25:0] exp_fields;
    } vec_t;

    function automatic vec_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                input logic [7:0] d, input logic [7:0] mo, input logic [7:0] cs,
                                input int bad_idx, input int es, input int ee, input logic [2:0] code,
                                input logic [4:0] eh, input logic [5:0] em, input logic [5:0] esec,
                                input logic [4:0] ed, input logic [3:0] emo);
        vec_t v;
        v.frame[0] = 8'hA5; v.frame[1] = h; v.frame[2] = m; v.frame[3] = s;
        v.frame[4] = d;     v.frame[5] = mo; v.frame[6] = cs;
        v.bad_stop_idx = bad_idx;
        v.exp_set      = es;
        v.exp_err      = ee;
        v.exp_code     = code;
        v.exp_fields   = {eh, em, esec, ed, emo};
        return v;
    endfunction

    task automatic idle_bits(input int n);
        rx = 1'b1;
        repeat (n * CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
`ifdef TIME_SET_RX_PARITY_EN
        rx = ^b;
        repeat (CPB) @(negedge clock);
`endif
        rx = !bad_stop;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
    endtask

    task automatic send_vec(input vec_t v);
        for (int j = 0; j < 7; j++) begin
            if (v.bad_stop_idx >= 0 && j > v.bad_stop_idx) break;
            send_byte(v.frame[j], j == v.bad_stop_idx);
        end
    endtask

    function automatic logic [25:0] fields();
        return {set_hour, set_minute, set_second, set_day, set_month};
    endfunction

    vec_t vecs [9];
    int   s0, e0;

    initial begin
        // Good checksum of 0C,22,05,0F,03 is 0x27; 0x2A is a deliberately wrong one.
        vecs[0] = mk(8'h0C, 8'h22, 8'h05, 8'h0F, 8'h03, 8'h27, -1, 1, 0, 3'd0, 5'd12, 6'd34, 6'd5,  5'd15, 4'd3);
        vecs[1] = mk(8'h0C, 8'h22, 8'h05, 8'h0F, 8'h03, 8'h2A, -1, 0, 1, 3'd3, 5'd12, 6'd34, 6'd5,  5'd15, 4'd3);
        vecs[2] = mk(8'h18, 8'h22, 8'h05, 8'h0F, 8'h03, 8'h33, -1, 0, 1, 3'd4, 5'd12, 6'd34, 6'd5,  5'd15, 4'd3);
        vecs[3] = mk(8'h0C, 8'h22, 8'h05, 8'h0F, 8'h03, 8'h27,  2, 0, 1, 3'd1, 5'd12, 6'd34, 6'd5,  5'd15, 4'd3);
        vecs[4] = mk(8'h17, 8'h3B, 8'h3B, 8'h1E, 8'h0B, 8'h02, -1, 1, 0, 3'd0, 5'd23, 6'd59, 6'd59, 5'd30, 4'd11);
        vecs[5] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h0C, 8'h0C, -1, 0, 1, 3'd4, 5'd23, 6'd59, 6'd59, 5'd30, 4'd11);
        vecs[6] = mk(8'h0C, 8'h22, 8'h05, 8'h1F, 8'h03, 8'h37, -1, 0, 1, 3'd4, 5'd23, 6'd59, 6'd59, 5'd30, 4'd11);
        vecs[7] = mk(8'h0A, 8'hA5, 8'h01, 8'h02, 8'h03, 8'hAF, -1, 0, 1, 3'd4, 5'd23, 6'd59, 6'd59, 5'd30, 4'd11);
        vecs[8] = mk(8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, -1, 1, 0, 3'd0, 5'd0,  6'd0,  6'd0,  5'd0,  4'd0);

        repeat (5) @(negedge clock);
        rx = 1'b0;
        repeat (3) @(negedge clock);
        check("reset outputs", {6'd0, set_valid, err_valid, busy, err_code, fields()}, 32'd0);
        rx = 1'b1;
        reset = 1'b1;
        idle_bits(2);

        for (int i = 0; i < 9; i++) begin
            s0 = set_cnt;
            e0 = err_cnt;
            send_vec(vecs[i]);
            idle_bits(4);
            check($sformatf("v%0d set_valid pulses", i), set_cnt - s0, vecs[i].exp_set);
            check($sformatf("v%0d err_valid pulses", i), err_cnt - e0, vecs[i].exp_err);
            if (vecs[i].exp_err != 0)
                check($sformatf("v%0d err_code", i), {29'd0, err_code}, {29'd0, vecs[i].exp_code});
            check($sformatf("v%0d set fields", i), {6'd0, fields()}, {6'd0, vecs[i].exp_fields});
            check($sformatf("v%0d busy idle", i), {31'd0, busy}, 32'd0);
        end

        // Inter-byte timeout: 18 idle bits is still inside the window, 23 is past it.
        s0 = set_cnt;
        e0 = err_cnt;
        send_byte(8'hA5, 1'b0);
        check("busy after sync", {31'd0, busy}, 32'd1);
        send_byte(8'h01, 1'b0);
        idle_bits(18);
        check("no early timeout", err_cnt - e0, 0);
        check("busy before timeout", {31'd0, busy}, 32'd1);
        idle_bits(5);
        check("timeout err pulse", err_cnt - e0, 1);
        check("timeout err_code", {29'd0, err_code}, 32'd5);
        check("busy after timeout", {31'd0, busy}, 32'd0);
        s0 = set_cnt;
        e0 = err_cnt;
        send_byte(8'h55, 1'b0);
        send_byte(8'h00, 1'b0);
        idle_bits(4);
        check("pre-sync bytes set", set_cnt - s0, 0);
        check("pre-sync bytes err", err_cnt - e0, 0);
        check("pre-sync busy", {31'd0, busy}, 32'd0);

        // Reset in the middle of a payload, then a full good frame.
        send_vec(vecs[0]);
        idle_bits(2);
        check("fields before reset", {6'd0, fields()}, {6'd0, vecs[0].exp_fields});
        send_byte(8'hA5, 1'b0);
        send_byte(8'h0C, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("mid-frame reset outputs", {6'd0, set_valid, err_valid, busy, err_code, fields()}, 32'd0);
        reset = 1'b1;
        idle_bits(2);
        s0 = set_cnt;
        e0 = err_cnt;
        send_vec(vecs[0]);
        idle_bits(4);
        check("post-reset set pulse", set_cnt - s0, 1);
        check("post-reset err pulse", err_cnt - e0, 0);
        check("post-reset fields", {6'd0, fields()}, {6'd0, vecs[0].exp_fields});

        check("set/err never together", both_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
